// File: rtl/layer_mixer_pkg.sv
// Shared types and constants for the layer mixer.
// Holds the layer-index enum, the enable-register bit positions, the pipeline
// depth, and the packed payload carried between the two pipeline stages.
package layer_mixer_pkg;

  localparam int unsigned COL_W      = 8;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned EN_W       = 3;

  // Bit positions in the layer-enable register {BGB, BGA, OBJ}
  localparam int unsigned EN_OBJ     = 0;
  localparam int unsigned EN_BGA     = 1;
  localparam int unsigned EN_BGB     = 2;

  // CE_PIX cycles from input capture to output update
  localparam int unsigned PIPE_DEPTH = 2;

  localparam logic [EN_W-1:0] EN_RESET = 3'b111;

  typedef enum logic [1:0] {
    LAYER_OBJ      = 2'd0,
    LAYER_BGA      = 2'd1,
    LAYER_BGB      = 2'd2,
    LAYER_BACKDROP = 2'd3
  } layer_e;

  // {palette, pixel} colour of one layer
  typedef struct packed {
    logic [NIB_W-1:0] pal;
    logic [NIB_W-1:0] pix;
  } col_t;

  // Stage-1 register contents
  typedef struct packed {
    col_t            obj;
    col_t            bga;
    col_t            bgb;
    logic            bga_pri;
    logic            bgb_pri;
    logic [EN_W-1:0] opq;
    logic            blank;
  } s1_t;

endpackage

// File: rtl/layer_prio_resolve.sv
// Combinational opacity and priority logic for the layer mixer.
// Ports:
//   obj_col/bga_col/bgb_col, en : raw layer colours and active enable mask
//   opq_c                       : per-layer opacity flags {BGB, BGA, OBJ}
//   s1_*                        : stage-1 registered colours, priorities, flags
//   winner_c, col_c             : winning layer and its output colour
module layer_prio_resolve
  import layer_mixer_pkg::*;
#(
  parameter logic [NIB_W-1:0] OPAQUE_MASK = 4'hF
) (
  input  col_t            obj_col,
  input  col_t            bga_col,
  input  col_t            bgb_col,
  input  logic [EN_W-1:0] en,
  output logic [EN_W-1:0] opq_c,
  input  col_t            s1_obj,
  input  col_t            s1_bga,
  input  col_t            s1_bgb,
  input  logic            s1_bga_pri,
  input  logic            s1_bgb_pri,
  input  logic [EN_W-1:0] s1_opq,
  output layer_e          winner_c,
  output col_t            col_c
);

  // Opacity: masked pixel nibble non-zero and layer enabled
  always_comb begin
    opq_c         = '0;
    opq_c[EN_OBJ] = en[EN_OBJ] & (|(obj_col.pix & OPAQUE_MASK));
    opq_c[EN_BGA] = en[EN_BGA] & (|(bga_col.pix & OPAQUE_MASK));
    opq_c[EN_BGB] = en[EN_BGB] & (|(bgb_col.pix & OPAQUE_MASK));
  end

  // Priority: high-pri BGA, high-pri BGB, OBJ, BGA, BGB, backdrop
  always_comb begin
    winner_c = LAYER_BACKDROP;
    col_c    = '{pal: s1_bgb.pal, pix: '0};
    if (s1_opq[EN_BGA] && s1_bga_pri) begin
      winner_c = LAYER_BGA;
      col_c    = s1_bga;
    end else if (s1_opq[EN_BGB] && s1_bgb_pri) begin
      winner_c = LAYER_BGB;
      col_c    = s1_bgb;
    end else if (s1_opq[EN_OBJ]) begin
      winner_c = LAYER_OBJ;
      col_c    = s1_obj;
    end else if (s1_opq[EN_BGA]) begin
      winner_c = LAYER_BGA;
      col_c    = s1_bga;
    end else if (s1_opq[EN_BGB]) begin
      winner_c = LAYER_BGB;
      col_c    = s1_bgb;
    end
  end

endmodule

// File: rtl/layer_mixer.sv
// Two-stage sprite/tilemap layer mixer feeding the palette stage.
// Ports:
//   CLK_32M, RESET       : clock, async active-high reset
//   CE_PIX               : pixel-rate clock enable
//   HBLANK, VBLANK       : blanking, aligned with layer inputs
//   OBJ_COL, BGA_COL/PRI, BGB_COL/PRI : layer colours and tile priorities
//   REG_WR, REG_DIN      : host write of the {BGB, BGA, OBJ} enable shadow
//   CA, CB, SELECT       : sprite index, tile index, sprite-select
//   BLANK_N              : low during (delayed) blank
module layer_mixer
  import layer_mixer_pkg::*;
#(
  parameter logic [NIB_W-1:0] OPAQUE_MASK = 4'hF
) (
  input  logic             CLK_32M,
  input  logic             RESET,
  input  logic             CE_PIX,
  input  logic             HBLANK,
  input  logic             VBLANK,
  input  logic [COL_W-1:0] OBJ_COL,
  input  logic [COL_W-1:0] BGA_COL,
  input  logic             BGA_PRI,
  input  logic [COL_W-1:0] BGB_COL,
  input  logic             BGB_PRI,
  input  logic             REG_WR,
  input  logic [EN_W-1:0]  REG_DIN,
  output logic [COL_W-1:0] CA,
  output logic [COL_W-1:0] CB,
  output logic             SELECT,
  output logic             BLANK_N
);

  logic [EN_W-1:0] shadow_en;
  logic [EN_W-1:0] active_en;
  logic            vblank_prev;
  logic            vblank_rise_c;
  s1_t             s1;
  logic            s1_vld;
  logic [EN_W-1:0] opq_c;
  layer_e          winner_c;
  col_t            col_c;

  assign vblank_rise_c = CE_PIX & VBLANK & ~vblank_prev;

  layer_prio_resolve #(
    .OPAQUE_MASK(OPAQUE_MASK)
  ) u_prio (
    .obj_col    (OBJ_COL),
    .bga_col    (BGA_COL),
    .bgb_col    (BGB_COL),
    .en         (active_en),
    .opq_c      (opq_c),
    .s1_obj     (s1.obj),
    .s1_bga     (s1.bga),
    .s1_bgb     (s1.bgb),
    .s1_bga_pri (s1.bga_pri),
    .s1_bgb_pri (s1.bgb_pri),
    .s1_opq     (s1.opq),
    .winner_c   (winner_c),
    .col_c      (col_c)
  );

  // Shadow enable: host writes land on any clock, latest write wins
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      shadow_en <= EN_RESET;
    end else if (REG_WR) begin
      shadow_en <= REG_DIN;
    end
  end

  // Active enable: picks up the pre-write shadow value on a VBLANK rise
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      active_en   <= EN_RESET;
      vblank_prev <= 1'b1;
    end else if (CE_PIX) begin
      vblank_prev <= VBLANK;
      if (vblank_rise_c) begin
        active_en <= shadow_en;
      end
    end
  end

  // Stage 1: capture inputs and opacity flags under the current mask
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      s1     <= '0;
      s1_vld <= 1'b0;
    end else if (CE_PIX) begin
      s1.obj     <= OBJ_COL;
      s1.bga     <= BGA_COL;
      s1.bgb     <= BGB_COL;
      s1.bga_pri <= BGA_PRI;
      s1.bgb_pri <= BGB_PRI;
      s1.opq     <= opq_c;
      s1.blank   <= HBLANK | VBLANK;
      s1_vld     <= 1'b1;
    end
  end

  // Stage 2: resolved winner updates only its own index; blank forces zero
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      CA      <= '0;
      CB      <= '0;
      SELECT  <= 1'b0;
      BLANK_N <= 1'b0;
    end else if (CE_PIX) begin
      if (!s1_vld || s1.blank) begin
        CA      <= '0;
        CB      <= '0;
        SELECT  <= 1'b0;
        BLANK_N <= 1'b0;
      end else begin
        BLANK_N <= 1'b1;
        if (winner_c == LAYER_OBJ) begin
          SELECT <= 1'b1;
          CA     <= col_c;
        end else begin
          SELECT <= 1'b0;
          CB     <= col_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_mixer.sv
// Self-checking bench for layer_mixer: directed scenarios plus random pixels
// checked against a pixel-level reference model.
module tb_layer_mixer;
  import layer_mixer_pkg::*;

  logic       CLK_32M = 1'b0;
  logic       RESET   = 1'b1;
  logic       CE_PIX  = 1'b0;
  logic       HBLANK  = 1'b0;
  logic       VBLANK  = 1'b0;
  logic [7:0] OBJ_COL = 8'h00;
  logic [7:0] BGA_COL = 8'h00;
  logic       BGA_PRI = 1'b0;
  logic [7:0] BGB_COL = 8'h00;
  logic       BGB_PRI = 1'b0;
  logic       REG_WR  = 1'b0;
  logic [2:0] REG_DIN = 3'b000;
  logic [7:0] CA;
  logic [7:0] CB;
  logic       SELECT;
  logic       BLANK_N;

  layer_mixer dut (
    .CLK_32M (CLK_32M),
    .RESET   (RESET),
    .CE_PIX  (CE_PIX),
    .HBLANK  (HBLANK),
    .VBLANK  (VBLANK),
    .OBJ_COL (OBJ_COL),
    .BGA_COL (BGA_COL),
    .BGA_PRI (BGA_PRI),
    .BGB_COL (BGB_COL),
    .BGB_PRI (BGB_PRI),
    .REG_WR  (REG_WR),
    .REG_DIN (REG_DIN),
    .CA      (CA),
    .CB      (CB),
    .SELECT  (SELECT),
    .BLANK_N (BLANK_N)
  );

  always #5 CLK_32M = ~CLK_32M;

  typedef struct packed {
    logic       blank;
    logic       sel;
    logic [7:0] col;
  } rec_t;

  // Reference model state
  logic [2:0] m_shadow, m_active;
  logic       m_prev;
  logic [7:0] m_ca, m_cb;
  logic       m_sel, m_bn;
  rec_t       m_q[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic rec_t ref_pixel(input logic [7:0] o, input logic [7:0] a, input logic ap,
                                     input logic [7:0] b, input logic bp, input logic hb,
                                     input logic vb, input logic [2:0] mask);
    rec_t r;
    logic oo, ao, bo;
    oo = mask[0] && ((o % 16) != 0);
    ao = mask[1] && ((a % 16) != 0);
    bo = mask[2] && ((b % 16) != 0);
    r.blank = hb | vb;
    r.sel   = 1'b0;
    if (ao && ap)      r.col = a;
    else if (bo && bp) r.col = b;
    else if (oo) begin r.sel = 1'b1; r.col = o; end
    else if (ao)       r.col = a;
    else if (bo)       r.col = b;
    else               r.col = b - (b % 16);
    return r;
  endfunction

  task automatic model_reset();
    m_shadow = 3'b111;
    m_active = 3'b111;
    m_prev   = 1'b1;
    m_ca = 8'h00; m_cb = 8'h00; m_sel = 1'b0; m_bn = 1'b0;
    m_q.delete();
  endtask

  task automatic model_ce(input logic [7:0] o, input logic [7:0] a, input logic ap,
                          input logic [7:0] b, input logic bp, input logic hb, input logic vb,
                          input logic wr, input logic [2:0] din);
    rec_t h;
    m_q.push_back(ref_pixel(o, a, ap, b, bp, hb, vb, m_active));
    if (m_q.size() >= int'(PIPE_DEPTH)) begin
      h = m_q.pop_front();
      if (h.blank) begin
        m_ca = 8'h00; m_cb = 8'h00; m_sel = 1'b0; m_bn = 1'b0;
      end else begin
        m_bn = 1'b1;
        if (h.sel) begin m_sel = 1'b1; m_ca = h.col; end
        else begin m_sel = 1'b0; m_cb = h.col; end
      end
    end
    if (vb && !m_prev) m_active = m_shadow;
    m_prev = vb;
    if (wr) m_shadow = din;
  endtask

  task automatic check(input string tag);
    vectors++;
    assert (CA === m_ca) else begin
      miscompares++; $error("FAIL %s CA got %h expected %h", tag, CA, m_ca); end
    vectors++;
    assert (CB === m_cb) else begin
      miscompares++; $error("FAIL %s CB got %h expected %h", tag, CB, m_cb); end
    vectors++;
    assert (SELECT === m_sel) else begin
      miscompares++; $error("FAIL %s SELECT got %b expected %b", tag, SELECT, m_sel); end
    vectors++;
    assert (BLANK_N === m_bn) else begin
      miscompares++; $error("FAIL %s BLANK_N got %b expected %b", tag, BLANK_N, m_bn); end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] ca, input logic [7:0] cb,
                            input logic sel, input logic bn);
    vectors++;
    assert ({CA, CB, SELECT, BLANK_N} === {ca, cb, sel, bn}) else begin
      miscompares++;
      $error("FAIL %s got CA=%h CB=%h SEL=%b BN=%b expected CA=%h CB=%h SEL=%b BN=%b",
             tag, CA, CB, SELECT, BLANK_N, ca, cb, sel, bn);
    end
  endtask

  // One pixel: CE cycle, then an idle cycle with scrambled inputs; starts/ends at negedge
  task automatic pix(input string tag, input logic [7:0] o, input logic [7:0] a, input logic ap,
                     input logic [7:0] b, input logic bp, input logic hb, input logic vb,
                     input logic wr = 1'b0, input logic [2:0] din = 3'b000);
    OBJ_COL = o; BGA_COL = a; BGA_PRI = ap; BGB_COL = b; BGB_PRI = bp;
    HBLANK = hb; VBLANK = vb; REG_WR = wr; REG_DIN = din; CE_PIX = 1'b1;
    @(posedge CLK_32M);
    model_ce(o, a, ap, b, bp, hb, vb, wr, din);
    #1;
    CE_PIX = 1'b0; REG_WR = 1'b0;
    OBJ_COL = 8'($urandom); BGA_COL = 8'($urandom); BGB_COL = 8'($urandom);
    BGA_PRI = 1'($urandom); BGB_PRI = 1'($urandom);
    HBLANK = 1'($urandom); VBLANK = 1'($urandom);
    @(posedge CLK_32M);
    @(negedge CLK_32M);
    check(tag);
  endtask

  task automatic reg_write(input logic [2:0] din);
    REG_WR = 1'b1; REG_DIN = din;
    @(posedge CLK_32M);
    m_shadow = din;
    #1 REG_WR = 1'b0;
    @(negedge CLK_32M);
  endtask

  initial begin
    int low_cnt, first_low, bad_blank;
    model_reset();
    repeat (3) @(negedge CLK_32M);
    expect_out("reset_state", 8'h00, 8'h00, 1'b0, 1'b0);
    RESET = 1'b0;

    // Sprite wins over low-priority tile
    pix("obj_a", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    expect_out("first_ce_held", 8'h00, 8'h00, 1'b0, 1'b0);
    pix("obj_b", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    expect_out("obj_wins", 8'h35, 8'h00, 1'b1, 1'b1);

    // High-priority BGA beats sprite; CA holds
    pix("bgapri_a", 8'h35, 8'h42, 1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
    pix("bgapri_b", 8'h35, 8'h42, 1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
    expect_out("bga_pri_wins", 8'h35, 8'h42, 1'b0, 1'b1);

    // All transparent -> backdrop
    pix("bd_a", 8'h30, 8'h40, 1'b0, 8'h9C & 8'hF0, 1'b0, 1'b0, 1'b0);
    pix("bd_b", 8'h30, 8'h40, 1'b0, 8'h90, 1'b0, 1'b0, 1'b0);
    pix("bd_c", 8'h50, 8'hE0, 1'b1, 8'h9C, 1'b1, 1'b0, 1'b0);
    expect_out("backdrop_prev", 8'h35, 8'h90, 1'b0, 1'b1);

    // Mid-frame mask write: no effect until VBLANK rise
    pix("mask_a", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    reg_write(3'b110);
    pix("mask_b", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    pix("mask_c", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    expect_out("mask_pending", 8'h35, 8'h71 & 8'h00 | 8'h90 & 8'h00 | CB, 1'b1, 1'b1);
    pix("mask_vb", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b1);
    pix("mask_d", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    expect_out("mask_blank", 8'h00, 8'h00, 1'b0, 1'b0);
    pix("mask_e", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    expect_out("mask_applied", 8'h00, 8'h42, 1'b0, 1'b1);

    // HBLANK for 3 pixels
    low_cnt = 0; first_low = -1; bad_blank = 0;
    for (int i = 0; i < 8; i++) begin
      pix("hblank", 8'h00, 8'h4A, 1'b0, 8'h7B, 1'b0, 1'(i < 3), 1'b0);
      if (!BLANK_N) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
        if (CA != 8'h00 || CB != 8'h00) bad_blank++;
      end
    end
    expect_out("hblank_after", 8'h00, 8'h4A, 1'b0, 1'b1);
    vectors++;
    assert (low_cnt === 3) else begin
      miscompares++; $error("FAIL hblank_len got %0d expected %0d", low_cnt, 3); end
    vectors++;
    assert (first_low === 1) else begin
      miscompares++; $error("FAIL hblank_delay got %0d expected %0d", first_low, 1); end
    vectors++;
    assert (bad_blank === 0) else begin
      miscompares++; $error("FAIL hblank_zero got %0d expected %0d", bad_blank, 0); end

    // Write coincident with VBLANK rise: active takes old shadow (110)
    pix("coin_a", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    pix("coin_vb", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b1, 1'b1, 3'b001);
    pix("coin_b", 8'h35, 8'h00, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    pix("coin_c", 8'h35, 8'h00, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    expect_out("coin_old_mask", 8'h00, 8'h71, 1'b0, 1'b1);
    pix("coin_vb2", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b1);
    pix("coin_d", 8'h35, 8'h42, 1'b1, 8'h71, 1'b1, 1'b0, 1'b0);
    pix("coin_e", 8'h35, 8'h42, 1'b1, 8'h71, 1'b1, 1'b0, 1'b0);
    expect_out("coin_new_mask", 8'h35, 8'h00, 1'b1, 1'b1);

    // All-zero mask -> backdrop only
    reg_write(3'b000);
    pix("zero_vb0", 8'h35, 8'h42, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    pix("zero_vb", 8'h35, 8'h42, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
    pix("zero_a", 8'h35, 8'h42, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    pix("zero_b", 8'h35, 8'h42, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    expect_out("zero_mask", 8'h00, 8'hA0, 1'b0, 1'b1);
    reg_write(3'b111);
    pix("restore_vb0", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    pix("restore_vb", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Random pixels against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) reg_write(3'($urandom));
      pix("random", 8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 9) == 0), 3'($urandom));
    end

    // Reset asserted mid-line with CE toggling
    reg_write(3'b111);
    pix("pre_rst_vb0", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    pix("pre_rst_vb", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    pix("pre_rst_a", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    pix("pre_rst_b", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    pix("pre_rst_c", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    expect_out("pre_rst", 8'h35, 8'h00, 1'b1, 1'b1);
    CE_PIX = 1'b1;
    @(posedge CLK_32M);
    #2 RESET = 1'b1;
    #1 expect_out("rst_immediate", 8'h00, 8'h00, 1'b0, 1'b0);
    model_reset();
    repeat (4) begin
      @(negedge CLK_32M);
      CE_PIX = ~CE_PIX;
    end
    @(negedge CLK_32M);
    CE_PIX = 1'b0;
    check("rst_held");
    RESET = 1'b0;
    pix("post_rst_a", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    expect_out("post_rst_first", 8'h00, 8'h00, 1'b0, 1'b0);
    pix("post_rst_b", 8'h35, 8'h42, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    expect_out("post_rst_second", 8'h35, 8'h00, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer_mixer.md
LAYER_MIXER -- requirements
Module: layer_mixer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  - OPAQUE_MASK, 4'hF: pixel-nibble bits tested for opacity.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  - CLK_32M, in, 1: sole clock. The block SHALL have one clock.
  - RESET, in, 1: asynchronous, active-high reset.
  - CE_PIX, in, 1: pixel-rate clock enable, one CLK_32M cycle wide.
  - HBLANK, in, 1: horizontal blank, aligned with the layer inputs.
  - VBLANK, in, 1: vertical blank, aligned with the layer inputs.
  - OBJ_COL, in, 8: sprite {palette[7:4], pixel[3:0]}.
  - BGA_COL, in, 8: tilemap A {palette, pixel}.
  - BGA_PRI, in, 1: tilemap A high-priority flag.
  - BGB_COL, in, 8: tilemap B {palette, pixel}.
  - BGB_PRI, in, 1: tilemap B high-priority flag.
  - REG_WR, in, 1: host write strobe for the layer-enable register.
  - REG_DIN, in, 3: layer-enable value, {BGB, BGA, OBJ}.
  - CA, out, 8: sprite palette index, to the palette stage CA input.
  - CB, out, 8: tile palette index, to the palette stage CB input.
  - SELECT, out, 1: 1 = palette stage uses CA (sprite), 0 = CB (tile).
  - BLANK_N, out, 1: low during blank; drives the palette stage CBLK/E2_N.

Function
REQ-003 A layer pixel SHALL be opaque iff (pixel[3:0] & OPAQUE_MASK) != 0 and its bit in the active enable register is 1.
REQ-004 Winner priority SHALL be, highest first: BGA opaque & BGA_PRI; BGB opaque & BGB_PRI; OBJ opaque; BGA opaque; BGB opaque; backdrop.
REQ-005 The backdrop SHALL be BGB_COL with pixel forced to 0, and SELECT=0.
REQ-006 When the winner is OBJ: SELECT=1, CA=OBJ_COL, and CB SHALL hold its previous value.
REQ-007 When the winner is a tile or the backdrop: SELECT=0, CB=winner colour, and CA SHALL hold its previous value.
REQ-008 Pipeline stage 1, on CE_PIX: register the inputs and compute the opacity flags.
REQ-009 Pipeline stage 2, on the next CE_PIX: resolve priority and update CA, CB, SELECT and BLANK_N.
REQ-010 Total latency SHALL be 2 CE_PIX cycles.
REQ-011 BLANK_N SHALL equal ~(HBLANK|VBLANK) delayed by the same 2 CE_PIX cycles.
REQ-012 While the delayed blank is active, CA, CB and SELECT SHALL be forced to 0.
REQ-013 No state SHALL change on cycles where CE_PIX=0, except shadow-register capture (REQ-014).
REQ-014 Shadow register: REG_WR SHALL load REG_DIN into the shadow register on any CLK_32M edge, independent of CE_PIX. A second write before transfer SHALL overwrite the first.
REQ-015 Active register transfer: the active register SHALL load the shadow register on the CLK_32M cycle where the VBLANK rising edge is detected in stage 1 on a CE_PIX cycle. The new mask SHALL therefore apply from the first pixel that follows.
REQ-016 REG_WR coincident with the transfer edge: the shadow register SHALL take the new value, and the active register SHALL take the old shadow value.
REQ-017 An all-zero enable mask SHALL produce backdrop only.

Reset
REQ-018 RESET SHALL immediately clear all pipeline registers.
REQ-019 During and after RESET: CA=0, CB=0, SELECT=0, BLANK_N=0.
REQ-020 During and after RESET: shadow and active registers = 3'b111; the VBLANK edge detector SHALL read as previous-VBLANK=1.
REQ-021 After RESET is released, the first valid output SHALL appear on the second CE_PIX. Until then outputs SHALL stay at reset values.

Structure
REQ-022 A shared package SHALL hold the layer-index enum (OBJ, BGA, BGB, BACKDROP), the enable-bit positions, and the pipeline depth constant (2).
REQ-023 One sub-module, layer_prio_resolve, SHALL be used: combinational opacity and priority logic returning winner enum and colour. All registers SHALL stay in layer_mixer.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  - OBJ_COL=8'h35, BGA_COL=8'h42 with BGA_PRI=0, BGB_COL=8'h71 -> 2 CE_PIX later: SELECT=1, CA=8'h35, BLANK_N=1.
  - Same inputs with BGA_PRI=1 -> SELECT=0, CB=8'h42, CA unchanged.
  - All pixel nibbles 0, BGB_COL=8'h9C -> SELECT=0, CB=8'h90.
  - REG_DIN=3'b110 written mid-frame while OBJ is opaque -> OBJ still wins until the next VBLANK rise, then CB shows the tile colour.
  - HBLANK pulsed for 3 CE_PIX -> BLANK_N low for exactly 3 CE_PIX, 2 CE_PIX later, with CA=CB=0 throughout.
  - RESET asserted mid-line with CE_PIX toggling -> outputs 0 and BLANK_N=0 immediately; after release, first valid pixel on the 2nd CE_PIX.
